// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - Score 4 match sequencer: turn countdown, win-check handshake, round/match scoring
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   placed, mover            disc committed this cycle and the player who placed it
//   turn                     player currently to move (the other one wins on timeout)
//   board_full               all cells occupied; a non-winning final move is a draw
//   chk_req / chk_ack        level request to the win-checker / one-cycle completion pulse
//   chk_win                  checker result, qualified by chk_ack
//   new_game                 one-cycle pulse, restart the whole match
//   win                      freezes the state-update block during round and match end
//   round_rst                one-cycle board clear at the start of each new round
//   seconds_left             ticks remaining in the current turn
//   score0, score1           round wins per player, saturating at WINS_TO_MATCH
//   match_over, winner       match decided and by whom
module turn_controller #(
    parameter int TICK_DIV      = 50_000_000,
    parameter int TURN_TICKS    = 30,
    parameter int HOLD_TICKS    = 3,
    parameter int WINS_TO_MATCH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       placed,
    input  logic       mover,
    input  logic       turn,
    input  logic       board_full,
    output logic       chk_req,
    input  logic       chk_ack,
    input  logic       chk_win,
    input  logic       new_game,
    output logic       win,
    output logic       round_rst,
    output logic [5:0] seconds_left,
    output logic [1:0] score0,
    output logic [1:0] score1,
    output logic       match_over,
    output logic       winner
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [5:0]    TURN_INIT = 6'(TURN_TICKS);
    localparam logic [1:0]    WINS      = 2'(WINS_TO_MATCH);

    typedef enum logic [1:0] {PLAY, CHECK, ROUND_END, MATCH_END} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tick_cnt, tick_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic [5:0]    seconds_nx;
    logic [1:0]    score0_nx, score1_nx;
    logic          chk_req_nx, win_nx, round_rst_nx, match_over_nx, winner_nx;
    logic          mover_q, mover_nx;
    logic          counting, tick;

    assign counting = (state == PLAY) || (state == ROUND_END);
    assign tick     = counting && (tick_cnt == TICK_LAST);

    function automatic logic [1:0] sat_inc(input logic [1:0] s);
        return (s == WINS) ? s : s + 2'd1;
    endfunction

    always_comb begin
        state_nx      = state;
        tick_nx       = '0;
        hold_nx       = hold_cnt;
        seconds_nx    = seconds_left;
        score0_nx     = score0;
        score1_nx     = score1;
        chk_req_nx    = chk_req;
        win_nx        = win;
        round_rst_nx  = 1'b0;
        match_over_nx = match_over;
        winner_nx     = winner;
        mover_nx      = mover_q;

        if (counting && !tick) begin
            tick_nx = tick_cnt + TW'(1);
        end

        if (new_game) begin
            state_nx      = PLAY;
            score0_nx     = 2'd0;
            score1_nx     = 2'd0;
            match_over_nx = 1'b0;
            chk_req_nx    = 1'b0;
            win_nx        = 1'b0;
            round_rst_nx  = 1'b1;
            seconds_nx    = TURN_INIT;
            hold_nx       = '0;
        end else begin
            case (state)
                PLAY: begin
                    // A placement wins over a coincident tick: the countdown
                    // is frozen at its current value for the check.
                    if (placed) begin
                        mover_nx   = mover;
                        chk_req_nx = 1'b1;
                        state_nx   = CHECK;
                    end else if (tick) begin
                        if (seconds_left == 6'd1) begin
                            seconds_nx = 6'd0;
                            if (turn) score0_nx = sat_inc(score0);
                            else      score1_nx = sat_inc(score1);
                            win_nx   = 1'b1;
                            hold_nx  = '0;
                            state_nx = ROUND_END;
                        end else begin
                            seconds_nx = seconds_left - 6'd1;
                        end
                    end
                end
                CHECK: begin
                    if (chk_ack) begin
                        chk_req_nx = 1'b0;
                        if (chk_win) begin
                            if (mover_q) score1_nx = sat_inc(score1);
                            else         score0_nx = sat_inc(score0);
                            win_nx   = 1'b1;
                            hold_nx  = '0;
                            state_nx = ROUND_END;
                        end else if (board_full) begin
                            win_nx   = 1'b1;
                            hold_nx  = '0;
                            state_nx = ROUND_END;
                        end else begin
                            seconds_nx = TURN_INIT;
                            state_nx   = PLAY;
                        end
                    end
                end
                ROUND_END: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            if ((score0 == WINS) || (score1 == WINS)) begin
                                match_over_nx = 1'b1;
                                winner_nx     = (score0 != WINS);
                                state_nx      = MATCH_END;
                            end else begin
                                round_rst_nx = 1'b1;
                                win_nx       = 1'b0;
                                seconds_nx   = TURN_INIT;
                                state_nx     = PLAY;
                            end
                        end else begin
                            hold_nx = hold_cnt + HW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        // Every state entry, and every restart, begins a fresh tick period.
        if ((state_nx != state) || new_game) begin
            tick_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= PLAY;
            tick_cnt     <= '0;
            hold_cnt     <= '0;
            seconds_left <= TURN_INIT;
            score0       <= 2'd0;
            score1       <= 2'd0;
            chk_req      <= 1'b0;
            win          <= 1'b0;
            round_rst    <= 1'b0;
            match_over   <= 1'b0;
            winner       <= 1'b0;
            mover_q      <= 1'b0;
        end else begin
            state        <= state_nx;
            tick_cnt     <= tick_nx;
            hold_cnt     <= hold_nx;
            seconds_left <= seconds_nx;
            score0       <= score0_nx;
            score1       <= score1_nx;
            chk_req      <= chk_req_nx;
            win          <= win_nx;
            round_rst    <= round_rst_nx;
            match_over   <= match_over_nx;
            winner       <= winner_nx;
            mover_q      <= mover_nx;
        end
    end
endmodule

// File: tb/tb_turn_controller.sv
// tb/tb_turn_controller.sv - self-checking bench for turn_controller: directed scenarios plus random play against a timeline model
module tb_turn_controller;
    localparam int TD = 4;
    localparam int TT = 3;
    localparam int HT = 2;
    localparam int W  = 2;

    localparam int P_PLAY  = 0;
    localparam int P_CHECK = 1;
    localparam int P_RE    = 2;
    localparam int P_ME    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       placed = 1'b0, mover = 1'b0, turn = 1'b0, board_full = 1'b0;
    logic       chk_ack = 1'b0, chk_win = 1'b0, new_game = 1'b0;
    logic       chk_req, win, round_rst, match_over, winner;
    logic [5:0] seconds_left;
    logic [1:0] score0, score1;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    turn_controller #(
        .TICK_DIV(TD), .TURN_TICKS(TT), .HOLD_TICKS(HT), .WINS_TO_MATCH(W)
    ) dut (
        .clk(clk), .rst(rst), .placed(placed), .mover(mover), .turn(turn),
        .board_full(board_full), .chk_req(chk_req), .chk_ack(chk_ack),
        .chk_win(chk_win), .new_game(new_game), .win(win), .round_rst(round_rst),
        .seconds_left(seconds_left), .score0(score0), .score1(score1),
        .match_over(match_over), .winner(winner)
    );

    // Model: phase plus cycles elapsed since entering it. The countdown is
    // derived from elapsed time, not from a tick counter.
    typedef struct {
        int ph;
        int el;
        int sf;
        int s0;
        int s1;
        bit mv;
        bit rr;
        bit wn;
    } model_t;

    model_t m;

    function automatic int sat_inc(input int s);
        return (s >= W) ? W : s + 1;
    endfunction

    function automatic model_t model_next(input model_t c, input bit r, input bit ng,
                                          input bit pl, input bit mvr, input bit tn,
                                          input bit ack, input bit cw, input bit full);
        model_t n;
        n    = c;
        n.rr = 1'b0;
        if (r) begin
            n.ph = P_PLAY; n.el = 0; n.sf = TT; n.s0 = 0; n.s1 = 0; n.mv = 0; n.wn = 0;
        end else if (ng) begin
            n.ph = P_PLAY; n.el = 0; n.sf = TT; n.s0 = 0; n.s1 = 0; n.rr = 1'b1;
        end else begin
            case (c.ph)
                P_PLAY: begin
                    if (pl) begin
                        n.mv = mvr;
                        n.sf = TT - c.el / TD;
                        n.ph = P_CHECK;
                    end else if (c.el + 1 == TT * TD) begin
                        if (tn) n.s0 = sat_inc(c.s0);
                        else    n.s1 = sat_inc(c.s1);
                        n.sf = 0;
                        n.ph = P_RE;
                        n.el = 0;
                    end else begin
                        n.el = c.el + 1;
                    end
                end
                P_CHECK: begin
                    if (ack) begin
                        n.el = 0;
                        if (cw) begin
                            if (c.mv) n.s1 = sat_inc(c.s1);
                            else      n.s0 = sat_inc(c.s0);
                            n.ph = P_RE;
                        end else if (full) begin
                            n.ph = P_RE;
                        end else begin
                            n.ph = P_PLAY;
                        end
                    end
                end
                P_RE: begin
                    if (c.el + 1 == HT * TD) begin
                        if (c.s0 == W || c.s1 == W) begin
                            n.ph = P_ME;
                            n.wn = (c.s0 != W);
                        end else begin
                            n.ph = P_PLAY;
                            n.el = 0;
                            n.rr = 1'b1;
                        end
                    end else begin
                        n.el = c.el + 1;
                    end
                end
                default: begin
                end
            endcase
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= model_next(m, rst, new_game, placed, mover, turn, chk_ack, chk_win, board_full);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_chk_req",    32'(chk_req),      32'(m.ph == P_CHECK));
            check("m_win",        32'(win),          32'(m.ph == P_RE || m.ph == P_ME));
            check("m_match_over", 32'(match_over),   32'(m.ph == P_ME));
            check("m_round_rst",  32'(round_rst),    32'(m.rr));
            check("m_winner",     32'(winner),       32'(m.wn));
            check("m_score0",     32'(score0),       32'(m.s0));
            check("m_score1",     32'(score1),       32'(m.s1));
            check("m_seconds",    32'(seconds_left),
                  32'((m.ph == P_PLAY) ? (TT - m.el / TD) : m.sf));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic place(input bit who);
        placed = 1'b1;
        mover  = who;
        step(1);
        placed = 1'b0;
    endtask

    task automatic ack(input bit w, input bit full);
        chk_ack    = 1'b1;
        chk_win    = w;
        board_full = full;
        step(1);
        chk_ack    = 1'b0;
        chk_win    = 1'b0;
        board_full = 1'b0;
    endtask

    task automatic restart();
        new_game = 1'b1;
        step(1);
        new_game = 1'b0;
    endtask

    initial begin
        // Reset state
        step(1);
        chk_en = 1'b1;
        check("rst_seconds",    32'(seconds_left), 3);
        check("rst_scores",     32'({score0, score1}), 0);
        check("rst_chk_req",    32'(chk_req), 0);
        check("rst_win",        32'(win), 0);
        check("rst_round_rst",  32'(round_rst), 0);
        check("rst_match_over", 32'(match_over), 0);
        check("rst_winner",     32'(winner), 0);
        rst = 1'b0;

        // 1: timeout with turn=0 gives player 1 the round
        step(4);  check("t1_sec_c4", 32'(seconds_left), 2);
        step(4);  check("t1_sec_c8", 32'(seconds_left), 1);
        step(3);  check("t1_win_c11", 32'(win), 0);
        step(1);  check("t1_sec_c12", 32'(seconds_left), 0);
        check("t1_win_c12", 32'(win), 1);
        check("t1_score1", 32'(score1), 1);
        step(7);  check("t1_win_c19", 32'(win), 1);
        check("t1_rr_c19", 32'(round_rst), 0);
        step(1);  check("t1_rr_c20", 32'(round_rst), 1);
        check("t1_win_c20", 32'(win), 0);
        step(1);  check("t1_rr_c21", 32'(round_rst), 0);

        // 2: non-winning move, ack five cycles after placement
        place(1'b0);
        for (int i = 1; i <= 5; i++) begin
            check("t2_chk_req_hi", 32'(chk_req), 1);
            if (i < 5) step(1);
        end
        ack(1'b0, 1'b0);
        check("t2_chk_req_lo", 32'(chk_req), 0);
        check("t2_seconds", 32'(seconds_left), 3);
        check("t2_scores", 32'({score0, score1}), 32'({2'd0, 2'd1}));

        // 3: fresh match, player 1 wins with ack in the first CHECK cycle
        restart();
        check("t3_ng_rr", 32'(round_rst), 1);
        check("t3_ng_scores", 32'({score0, score1}), 0);
        step(1);
        check("t3_ng_rr_once", 32'(round_rst), 0);
        place(1'b1);
        ack(1'b1, 1'b0);
        check("t3_score1", 32'(score1), 1);
        for (int i = 0; i < 8; i++) begin
            check("t3_win_hold", 32'(win), 1);
            step(1);
        end
        check("t3_rr", 32'(round_rst), 1);
        check("t3_win_off", 32'(win), 0);
        step(1);
        check("t3_rr_once", 32'(round_rst), 0);

        // 4: player 0 takes two rounds and the match
        place(1'b0);
        ack(1'b1, 1'b0);
        check("t4_score0_1", 32'(score0), 1);
        step(8);
        check("t4_rr", 32'(round_rst), 1);
        place(1'b0);
        ack(1'b1, 1'b0);
        check("t4_score0_2", 32'(score0), 2);
        step(8);
        check("t4_match_over", 32'(match_over), 1);
        check("t4_winner", 32'(winner), 0);
        step(20);
        check("t4_win_held", 32'(win), 1);
        place(1'b1);
        check("t4_placed_ignored", 32'(chk_req), 0);
        restart();
        check("t4_ng_scores", 32'({score0, score1}), 0);
        check("t4_ng_match_over", 32'(match_over), 0);
        check("t4_ng_rr", 32'(round_rst), 1);
        step(1);
        check("t4_ng_rr_once", 32'(round_rst), 0);

        // 5: draw on a full board
        place(1'b1);
        ack(1'b0, 1'b1);
        check("t5_win", 32'(win), 1);
        check("t5_scores", 32'({score0, score1}), 0);
        step(8);
        check("t5_rr", 32'(round_rst), 1);
        check("t5_scores_after", 32'({score0, score1}), 0);

        // 6a: placement on the timeout tick beats the timeout
        step(11);
        place(1'b0);
        check("t6_chk_req", 32'(chk_req), 1);
        check("t6_no_score", 32'({score0, score1}), 0);
        check("t6_no_win", 32'(win), 0);
        check("t6_seconds", 32'(seconds_left), 1);
        ack(1'b0, 1'b0);
        check("t6_back_play", 32'(seconds_left), 3);

        // 6b: reset during CHECK, late ack ignored
        place(1'b1);
        ack(1'b1, 1'b0);
        step(8);
        place(1'b0);
        check("t6_req_before_rst", 32'(chk_req), 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_rst_req", 32'(chk_req), 0);
        check("t6_rst_scores", 32'({score0, score1}), 0);
        ack(1'b1, 1'b0);
        check("t6_late_ack_scores", 32'({score0, score1}), 0);
        check("t6_late_ack_win", 32'(win), 0);

        // Random play checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            turn       = 1'($urandom_range(0, 1));
            placed     = ($urandom_range(0, 7) == 0);
            mover      = 1'($urandom_range(0, 1));
            board_full = ($urandom_range(0, 3) == 0);
            chk_ack    = ($urandom_range(0, 3) == 0);
            chk_win    = 1'($urandom_range(0, 1));
            new_game   = ($urandom_range(0, 299) == 0);
            rst        = ($urandom_range(0, 999) == 0);
            step(1);
        end
        rst = 1'b0; placed = 1'b0; chk_ack = 1'b0; new_game = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/turn_controller.md
# turn_controller

Match-level sequencer for the Score 4 game. It sits above the board state-update block and a multi-cycle win-checker. It runs a per-turn countdown, hands every placed disc to the win-checker through a request/acknowledge handshake, and drives the `win` freeze input of the state-update block. It also keeps each player's round score, clears the board between rounds, and declares a best-of-N match winner.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per countdown tick (1 s at 50 MHz); ≥ 2.
- `TURN_TICKS`, 30: ticks allowed per turn; 1..63.
- `HOLD_TICKS`, 3: ticks the round result is held before the next round; ≥ 1.
- `WINS_TO_MATCH`, 3: round wins needed to take the match; 1..3.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `placed` in 1: one-cycle pulse, a disc was committed to the board.
- `mover` in 1: player (0/1) who placed the disc; valid only with `placed`.
- `turn` in 1: player currently to move.
- `board_full` in 1: all 42 cells occupied.
- `chk_req` out 1: win-check request, level.
- `chk_ack` in 1: win-check done, one-cycle pulse.
- `chk_win` in 1: last move made four in a row; valid only with `chk_ack`.
- `new_game` in 1: one-cycle pulse, restart the match.
- `win` out 1: freezes the state-update block; high in ROUND_END and MATCH_END.
- `round_rst` out 1: one-cycle pulse that clears the board; ORed into the state-update reset.
- `seconds_left` out 6: remaining ticks in the current turn.
- `score0`, `score1` out 2: round wins per player.
- `match_over` out 1: match decided.
- `winner` out 1: match winner; valid while `match_over`=1.

## Operation
- States: PLAY, CHECK, ROUND_END, MATCH_END. All outputs are registered.
- Reset values:
  - state PLAY, `seconds_left`=TURN_TICKS, tick counter 0;
  - scores 0, `chk_req` 0, `win` 0, `round_rst` 0, `match_over` 0, `winner` 0.
- Tick counter:
  - counts 0..TICK_DIV-1 and wraps; the wrap cycle is a "tick";
  - runs only in PLAY and ROUND_END, held at 0 elsewhere;
  - cleared on every state entry.
- PLAY:
  - each tick decrements `seconds_left`.
  - A tick with `seconds_left`=1 is a timeout: `seconds_left`→0, player ~`turn` scores one round, go to ROUND_END.
  - `placed`=1: latch `mover`, set `chk_req`=1, go to CHECK. `placed` takes priority over a same-cycle timeout.
- CHECK:
  - `seconds_left` is frozen and `chk_req` is held until `chk_ack`.
  - On `chk_ack`, `chk_req` drops. Then, in priority order:
    - `chk_win`=1: latched mover's score +1, go to ROUND_END;
    - `board_full`=1: draw, no score change, go to ROUND_END;
    - otherwise: back to PLAY, `seconds_left`=TURN_TICKS, tick counter 0.
- ROUND_END:
  - `win`=1; stays for HOLD_TICKS ticks.
  - Then, if either score equals WINS_TO_MATCH: go to MATCH_END, `match_over`=1, `winner` = that player.
  - Otherwise: `round_rst` pulses once, `win`=0, `seconds_left`=TURN_TICKS, go to PLAY.
- MATCH_END: `win`=1; waits for `new_game`.
- `new_game`, in any state:
  - scores 0, `match_over`=0, `chk_req`=0, `win`=0;
  - `round_rst` pulses once, `seconds_left`=TURN_TICKS, go to PLAY.
  - Takes priority over every other event in that cycle. `rst` overrides `new_game`.
- Ignored inputs:
  - `placed` outside PLAY;
  - `chk_ack` outside CHECK;
  - `chk_win` without `chk_ack`.
- Scores saturate at WINS_TO_MATCH; no wrap.

## Timing
- `placed` in cycle N: state CHECK and `chk_req`=1 from N+1.
- `chk_ack` in cycle M: `chk_req`=0 and new state from M+1. Ack in the same cycle `chk_req` first rises is legal.
- Turn timeout: exactly TURN_TICKS·TICK_DIV cycles after entry to PLAY, the state is ROUND_END.
- ROUND_END lasts HOLD_TICKS·TICK_DIV cycles. `round_rst` is high in the first cycle of the following PLAY.
- `new_game` in cycle N: `round_rst`=1 in N+1 only.
- `rst` mid-CHECK: `chk_req`=0 the next cycle; a late `chk_ack` is ignored.

## Test plan
Bench parameters: TICK_DIV=4, TURN_TICKS=3, HOLD_TICKS=2, WINS_TO_MATCH=2.

1. Reset, `turn`=0, no `placed` for 12 cycles:
   - `seconds_left` 3→2→1→0 at cycles 4/8/12;
   - `score1`=1, `win`=1 from cycle 12;
   - after 8 more cycles, `round_rst` pulses once and `win`=0.
2. `placed`, `mover`=0; `chk_ack` 5 cycles later with `chk_win`=0, `board_full`=0:
   - `chk_req` high exactly 5 cycles;
   - state back to PLAY, `seconds_left`=3, scores unchanged.
3. `placed`, `mover`=1; `chk_ack` with `chk_win`=1:
   - `score1`+1, `win` high 8 cycles, then a single `round_rst` pulse.
4. Player 0 wins two rounds:
   - `match_over`=1, `winner`=0, `win` stays 1 indefinitely;
   - `new_game` → scores 0, `match_over`=0, one `round_rst` pulse.
5. `chk_ack` with `chk_win`=0 and `board_full`=1:
   - draw: ROUND_END with no score change, then PLAY.
6. Boundary and priority checks:
   - `placed` on the timeout tick → CHECK, no score.
   - `rst` while `chk_req`=1 → `chk_req`=0 next cycle, scores 0, later `chk_ack` ignored.
